// File: rtl/vga_pkg.sv
// Shared VGA drawing constants, rectangle-fill FSM states and command bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int HD         = 1280;
  localparam int VD         = 1024;
  localparam int X_BITS     = 11;
  localparam int Y_BITS     = 11;
  localparam int COLOR_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } rect_state_e;

  typedef struct packed {
    logic [X_BITS-1:0]     x0;
    logic [Y_BITS-1:0]     y0;
    logic [X_BITS-1:0]     x1;
    logic [Y_BITS-1:0]     y1;
    logic [COLOR_BITS-1:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/rect_cmd_norm.sv
// Rectangle command normaliser: orders corners into min/max and optionally clips.
// Latency: combinational; the fill engine registers the result on accept.
// Backpressure: none, pure function of the command inputs.
//
// Ports: i_cmd (raw corners + colour) -> o_xmin/o_xmax/o_ymin/o_ymax/o_color,
//        o_empty (rectangle lies fully off-screen; only with clipping).
// Build option: RECT_FILL_CLIP_EN enables clamping of xmax/ymax to the visible
// area and detection of fully off-screen rectangles.
module rect_cmd_norm
`ifdef RECT_FILL_CLIP_EN
#(
  parameter int HD = vga_pkg::HD,
  parameter int VD = vga_pkg::VD
)
`endif
(
  input  vga_pkg::rect_cmd_t              i_cmd,
  output logic [vga_pkg::X_BITS-1:0]      o_xmin,
  output logic [vga_pkg::X_BITS-1:0]      o_xmax,
  output logic [vga_pkg::Y_BITS-1:0]      o_ymin,
  output logic [vga_pkg::Y_BITS-1:0]      o_ymax,
  output logic [vga_pkg::COLOR_BITS-1:0]  o_color,
  output logic                            o_empty
);
  import vga_pkg::*;

  logic [X_BITS-1:0] w_xmax_raw;
  logic [Y_BITS-1:0] w_ymax_raw;

  assign o_xmin     = (i_cmd.x0 <= i_cmd.x1) ? i_cmd.x0 : i_cmd.x1;
  assign w_xmax_raw = (i_cmd.x0 <= i_cmd.x1) ? i_cmd.x1 : i_cmd.x0;
  assign o_ymin     = (i_cmd.y0 <= i_cmd.y1) ? i_cmd.y0 : i_cmd.y1;
  assign w_ymax_raw = (i_cmd.y0 <= i_cmd.y1) ? i_cmd.y1 : i_cmd.y0;
  assign o_color    = i_cmd.color;

`ifdef RECT_FILL_CLIP_EN
  localparam logic [X_BITS-1:0] XLAST = X_BITS'(HD - 1);
  localparam logic [Y_BITS-1:0] YLAST = Y_BITS'(VD - 1);

  assign o_xmax  = (w_xmax_raw > XLAST) ? XLAST : w_xmax_raw;
  assign o_ymax  = (w_ymax_raw > YLAST) ? YLAST : w_ymax_raw;
  // xmin >= HD is the same as xmin > HD-1; written this way to stay in X_BITS.
  assign o_empty = (o_xmin > XLAST) || (o_ymin > YLAST);
`else
  assign o_xmax  = w_xmax_raw;
  assign o_ymax  = w_ymax_raw;
  assign o_empty = 1'b0;
`endif

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: one command in, one framebuffer write per cycle in raster order.
// Latency: first write one cycle after accept; done_o one cycle after the last write.
// Backpressure: cmd_ready_o only in IDLE (no queueing); stall_i freezes pixel generation.
//
// Ports: clk_i/rst_i (sync, active-high); cmd_valid_i/cmd_ready_o with cmd_x0/x1/y0/y1/color;
//        stall_i; addr_x_o/addr_y_o/color_o/we_o to the framebuffer; busy_o, done_o.
// Build option: RECT_FILL_CLIP_EN clips commands to HD x VD.
module rect_fill_engine #(
  parameter int X_BITS     = vga_pkg::X_BITS,
  parameter int Y_BITS     = vga_pkg::Y_BITS,
`ifdef RECT_FILL_CLIP_EN
  parameter int HD         = vga_pkg::HD,
  parameter int VD         = vga_pkg::VD,
`endif
  parameter int COLOR_BITS = vga_pkg::COLOR_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [X_BITS-1:0]     cmd_x0_i,
  input  logic [X_BITS-1:0]     cmd_x1_i,
  input  logic [Y_BITS-1:0]     cmd_y0_i,
  input  logic [Y_BITS-1:0]     cmd_y1_i,
  input  logic [COLOR_BITS-1:0] cmd_color_i,
  input  logic                  stall_i,
  output logic [X_BITS-1:0]     addr_x_o,
  output logic [Y_BITS-1:0]     addr_y_o,
  output logic [COLOR_BITS-1:0] color_o,
  output logic                  we_o,
  output logic                  busy_o,
  output logic                  done_o
);
  import vga_pkg::*;

  rect_state_e           r_state, w_state_nxt;
  rect_cmd_t             w_cmd;
  logic [X_BITS-1:0]     w_xmin, w_xmax, r_x, r_xmin, r_xmax;
  logic [Y_BITS-1:0]     w_ymin, w_ymax, r_y, r_ymax;
  logic [COLOR_BITS-1:0] w_color, r_color;
  logic                  w_empty, w_accept, w_adv, w_x_last, w_y_last;

  assign w_cmd = '{x0: cmd_x0_i, y0: cmd_y0_i, x1: cmd_x1_i, y1: cmd_y1_i, color: cmd_color_i};

  rect_cmd_norm
`ifdef RECT_FILL_CLIP_EN
    #(.HD(HD), .VD(VD))
`endif
  u_norm (
    .i_cmd   (w_cmd),
    .o_xmin  (w_xmin),
    .o_xmax  (w_xmax),
    .o_ymin  (w_ymin),
    .o_ymax  (w_ymax),
    .o_color (w_color),
    .o_empty (w_empty)
  );

  assign cmd_ready_o = (r_state == IDLE);
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_adv       = (r_state == FILL) & ~stall_i;
  assign w_x_last    = (r_x == r_xmax);
  assign w_y_last    = (r_y == r_ymax);

  assign addr_x_o = r_x;
  assign addr_y_o = r_y;
  assign color_o  = r_color;
  assign we_o     = w_adv;
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_empty ? DONE : FILL;
      FILL: if (w_adv && w_x_last && w_y_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x     <= w_xmin;
        r_y     <= w_ymin;
        r_xmin  <= w_xmin;
        r_xmax  <= w_xmax;
        r_ymax  <= w_ymax;
        r_color <= w_color;
      end else if (w_adv) begin
        // The final pixel leaves the address where it is, so x/y never step
        // past xmax/ymax and cannot wrap at the top of the coordinate range.
        if (!w_x_last) begin
          r_x <= r_x + 1'b1;
        end else if (!w_y_last) begin
          r_x <= r_xmin;
          r_y <= r_y + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [10:0] cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i;
  logic [1:0]  cmd_color_i;
  logic        stall_i;
  logic [10:0] addr_x_o, addr_y_o;
  logic [1:0]  color_o;
  logic        we_o, busy_o, done_o;

  rect_fill_engine dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_x0_i    (cmd_x0_i),
    .cmd_x1_i    (cmd_x1_i),
    .cmd_y0_i    (cmd_y0_i),
    .cmd_y1_i    (cmd_y1_i),
    .cmd_color_i (cmd_color_i),
    .stall_i     (stall_i),
    .addr_x_o    (addr_x_o),
    .addr_y_o    (addr_y_o),
    .color_o     (color_o),
    .we_o        (we_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference pixel list for the current command, in raster order.
  int ex_q[$];
  int ey_q[$];
  int wr_count, last_x, last_y;

  task automatic build(input int x0, input int y0, input int x1, input int y1);
    int xmn, xmx, ymn, ymx;
    ex_q.delete();
    ey_q.delete();
    xmn = (x0 < x1) ? x0 : x1;
    xmx = (x0 < x1) ? x1 : x0;
    ymn = (y0 < y1) ? y0 : y1;
    ymx = (y0 < y1) ? y1 : y0;
`ifdef RECT_FILL_CLIP_EN
    if (xmx > 1279) xmx = 1279;
    if (ymx > 1023) ymx = 1023;
    if (xmn >= 1280 || ymn >= 1024) return;
`endif
    for (int y = ymn; y <= ymx; y++)
      for (int x = xmn; x <= xmx; x++) begin
        ex_q.push_back(x);
        ey_q.push_back(y);
      end
  endtask

  task automatic drive_garbage();
    cmd_x0_i    = 11'($urandom);
    cmd_x1_i    = 11'($urandom);
    cmd_y0_i    = 11'($urandom);
    cmd_y1_i    = 11'($urandom);
    cmd_color_i = 2'($urandom);
  endtask

  // stall_mode: 0 none, 1 random, 2 stall on cycles 3..5 after accept.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input int col, input int stall_mode, input string name);
    int  idx, cyc, stalls, n;
    bit  seen, abort;
    build(x0, y0, x1, y1);
    n = ex_q.size();
    @(negedge clk_i);
    stall_i     = 1'($urandom);
    cmd_valid_i = 1'b1;
    cmd_x0_i = 11'(x0); cmd_y0_i = 11'(y0);
    cmd_x1_i = 11'(x1); cmd_y1_i = 11'(y1);
    cmd_color_i = 2'(col);
    #1;
    n_tests++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_at_accept: got %b want 1", name, cmd_ready_o);
    end
    idx = 0; cyc = 0; stalls = 0; seen = 0; abort = 0;
    wr_count = 0; last_x = -1; last_y = -1;
    while (!seen && !abort && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      drive_garbage();
      case (stall_mode)
        1: stall_i = ($urandom_range(0, 3) == 0);
        2: stall_i = (cyc >= 3 && cyc <= 5);
        default: stall_i = 1'b0;
      endcase
      #1;
      if (we_o === 1'b1) begin
        wr_count++;
        last_x = int'(addr_x_o);
        last_y = int'(addr_y_o);
      end
      n_tests++;
      if (done_o === 1'b1) begin
        seen = 1;
        if (idx != n || cyc != n + stalls + 1) begin
          n_fail++;
          $display("FAIL %s done: writes %0d latency %0d, want writes %0d latency %0d",
                   name, idx, cyc, n, n + stalls + 1);
        end
      end else if (idx >= n) begin
        abort = 1;
        n_fail++;
        $display("FAIL %s overrun: we=%b addr=(%0d,%0d) after %0d writes, want done_o",
                 name, we_o, addr_x_o, addr_y_o, n);
      end else begin
        if (we_o !== !stall_i || busy_o !== 1'b1 || cmd_ready_o !== 1'b0 ||
            int'(addr_x_o) != ex_q[idx] || int'(addr_y_o) != ey_q[idx] ||
            int'(color_o) != col) begin
          n_fail++;
          $display("FAIL %s pixel%0d: we=%b busy=%b rdy=%b (%0d,%0d) c=%0d, want we=%b busy=1 rdy=0 (%0d,%0d) c=%0d",
                   name, idx, we_o, busy_o, cmd_ready_o, addr_x_o, addr_y_o, color_o,
                   !stall_i, ex_q[idx], ey_q[idx], col);
        end
        if (stall_i) stalls++;
        else idx++;
      end
    end
    if (!seen && !abort) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no done_o after %0d cycles", name, cyc);
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    stall_i     = 1'b0;
    #1;
    n_tests++;
    if (done_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b rdy=%b busy=%b, want 0 1 0",
               name, done_o, cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b1; stall_i = 1'b0;
    drive_garbage();
    repeat (3) @(negedge clk_i);
    cmd_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (addr_x_o !== 11'd0 || addr_y_o !== 11'd0 || color_o !== 2'd0 || we_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: x=%0d y=%0d c=%0d we=%b busy=%b done=%b rdy=%b, want 0 0 0 0 0 0 1",
               addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o, cmd_ready_o);
    end
  endtask

  task automatic test_basic();
    run_cmd(10, 20, 12, 21, 2, 0, "basic");
    n_tests++;
    if (wr_count != 6 || last_x != 12 || last_y != 21) begin
      n_fail++;
      $display("FAIL basic_count: %0d writes last (%0d,%0d), want 6 last (12,21)", wr_count, last_x, last_y);
    end
    run_cmd(12, 21, 10, 20, 2, 0, "swapped");
    n_tests++;
    if (wr_count != 6) begin
      n_fail++;
      $display("FAIL swapped_count: %0d writes, want 6", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_x0_i = 11'd0; cmd_y0_i = 11'd0; cmd_x1_i = 11'd0; cmd_y1_i = 11'd0;
    cmd_color_i = 2'd1; stall_i = 1'b0;
    // N+1: first (only) write; second command already presented and held.
    @(negedge clk_i);
    cmd_x0_i = 11'd6; cmd_y0_i = 11'd5; cmd_x1_i = 11'd5; cmd_y1_i = 11'd5; cmd_color_i = 2'd3;
    #1;
    n_tests++;
    if (we_o !== 1'b1 || addr_x_o !== 11'd0 || addr_y_o !== 11'd0 || color_o !== 2'd1 || cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n1: we=%b (%0d,%0d) c=%0d rdy=%b, want 1 (0,0) 1 0", we_o, addr_x_o, addr_y_o, color_o, cmd_ready_o);
    end
    @(negedge clk_i); #1;
    n_tests++;
    if (done_o !== 1'b1 || we_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n2: done=%b we=%b rdy=%b, want 1 0 0", done_o, we_o, cmd_ready_o);
    end
    @(negedge clk_i); #1;
    n_tests++;
    if (cmd_ready_o !== 1'b1 || done_o !== 1'b0 || we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n3: rdy=%b done=%b we=%b, want 1 0 0", cmd_ready_o, done_o, we_o);
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    drive_garbage();
    #1;
    n_tests++;
    if (we_o !== 1'b1 || addr_x_o !== 11'd5 || addr_y_o !== 11'd5 || color_o !== 2'd3) begin
      n_fail++;
      $display("FAIL b2b_n4: we=%b (%0d,%0d) c=%0d, want 1 (5,5) 3", we_o, addr_x_o, addr_y_o, color_o);
    end
    @(negedge clk_i); #1;
    n_tests++;
    if (we_o !== 1'b1 || addr_x_o !== 11'd6 || addr_y_o !== 11'd5) begin
      n_fail++;
      $display("FAIL b2b_n5: we=%b (%0d,%0d), want 1 (6,5)", we_o, addr_x_o, addr_y_o);
    end
    @(negedge clk_i); #1;
    n_tests++;
    if (done_o !== 1'b1 || we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_n6: done=%b we=%b, want 1 0", done_o, we_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_stall();
    run_cmd(0, 0, 3, 0, 1, 2, "stall");
    n_tests++;
    if (wr_count != 4 || last_x != 3) begin
      n_fail++;
      $display("FAIL stall_count: %0d writes last x %0d, want 4 last x 3", wr_count, last_x);
    end
  endtask

  task automatic test_reset_mid();
    bit got_done = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; stall_i = 1'b0;
    cmd_x0_i = 11'd0; cmd_y0_i = 11'd0; cmd_x1_i = 11'd7; cmd_y1_i = 11'd7; cmd_color_i = 2'd2;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (we_o !== 1'b1 || addr_x_o !== 11'd2 || addr_y_o !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid_third: we=%b (%0d,%0d), want 1 (2,0)", we_o, addr_x_o, addr_y_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (we_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: we=%b busy=%b rdy=%b done=%b, want 0 0 1 0", we_o, busy_o, cmd_ready_o, done_o);
    end
    repeat (80) begin
      @(negedge clk_i); #1;
      if (done_o === 1'b1 || we_o === 1'b1) got_done = 1;
    end
    n_tests++;
    if (got_done) begin
      n_fail++;
      $display("FAIL rstmid_quiet: done/we seen after reset, want none");
    end
  endtask

  task automatic test_clip();
    run_cmd(1270, 1020, 1300, 1030, 1, 0, "clip_edge");
    n_tests++;
`ifdef RECT_FILL_CLIP_EN
    if (wr_count != 40 || last_x != 1279 || last_y != 1023) begin
      n_fail++;
      $display("FAIL clip_edge_count: %0d writes last (%0d,%0d), want 40 last (1279,1023)", wr_count, last_x, last_y);
    end
    run_cmd(1300, 0, 1310, 5, 3, 0, "clip_off");
    n_tests++;
    if (wr_count != 0) begin
      n_fail++;
      $display("FAIL clip_off_count: %0d writes, want 0", wr_count);
    end
`else
    if (wr_count != 341 || last_x != 1300 || last_y != 1030) begin
      n_fail++;
      $display("FAIL noclip_count: %0d writes last (%0d,%0d), want 341 last (1300,1030)", wr_count, last_x, last_y);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int x0, y0, x1, y1;
      if (i % 2 == 0) begin
        x0 = $urandom_range(0, 2047);
        y0 = $urandom_range(0, 2047);
      end else begin
        x0 = $urandom_range(1260, 1290);
        y0 = $urandom_range(1000, 1030);
      end
      x1 = x0 + $urandom_range(0, 12) - 6;
      y1 = y0 + $urandom_range(0, 8) - 4;
      if (x1 < 0) x1 = 0;
      if (x1 > 2047) x1 = 2047;
      if (y1 < 0) y1 = 0;
      if (y1 > 2047) y1 = 2047;
      run_cmd(x0, y0, x1, y1, int'($urandom_range(0, 3)), 1, "random");
    end
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; stall_i = 1'b0;
    cmd_x0_i = '0; cmd_x1_i = '0; cmd_y0_i = '0; cmd_y1_i = '0; cmd_color_i = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_clip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Drawing stage directly upstream of the VGA framebuffer write port. Accepts one rectangle-fill command at a time over a valid/ready handshake and produces one framebuffer write per cycle: pixel address, colour and write enable, in raster order. Its outputs connect one-to-one to the framebuffer's `addr_x`/`addr_y`/`color`/`we` inputs, which accept a write every cycle. `stall_i` gives a shared-port arbiter a way to pause it.

## Interface
- `X_BITS`, 11: x coordinate width.
- `Y_BITS`, 11: y coordinate width.
- `HD`, 1280: visible width in pixels. Used only for clipping.
- `VD`, 1024: visible height in pixels. Used only for clipping.
- `COLOR_BITS`, 2: colour index width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: engine can accept a command.
- `cmd_x0_i`, `cmd_x1_i` in X_BITS: rectangle corner x coordinates (inclusive).
- `cmd_y0_i`, `cmd_y1_i` in Y_BITS: rectangle corner y coordinates (inclusive).
- `cmd_color_i` in COLOR_BITS: fill colour.
- `stall_i` in 1: freeze pixel generation.
- `addr_x_o` out X_BITS: write x.
- `addr_y_o` out Y_BITS: write y.
- `color_o` out COLOR_BITS: write colour.
- `we_o` out 1: write strobe.
- `busy_o` out 1: command in progress.
- `done_o` out 1: one-cycle pulse on command completion.

## Operation
- FSM states: IDLE, FILL, DONE.
- Reset values: state=IDLE; `addr_x_o`=0; `addr_y_o`=0; `color_o`=0; `we_o`=0; `busy_o`=0; `done_o`=0; `cmd_ready_o`=1.
- `cmd_ready_o` = (state==IDLE). A command is accepted on a cycle with `cmd_valid_i & cmd_ready_o`. Commands are never queued; while busy, `cmd_valid_i` is ignored.
- On accept, corners are normalised: xmin=min(x0,x1), xmax=max(x0,x1); ymin and ymax likewise. These values and the colour are latched. Later changes on the `cmd_*` inputs have no effect.
- IDLE→FILL on accept. Address registers load (xmin, ymin).
- FILL behaviour:
  - `we_o` = ~`stall_i` (combinational).
  - On a non-stalled cycle the address advances: x+1. When x==xmax, x wraps to xmin and y increments.
  - A non-stalled cycle with x==xmax and y==ymax is the last write. The next state is DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o` = (state != IDLE).
- Write count = (xmax-xmin+1)·(ymax-ymin+1). There are no duplicated or skipped pixels.
- All coordinate arithmetic is unsigned, in X_BITS/Y_BITS. Wrap comparisons use `==`; the address never overflows because advancement stops at xmax/ymax.
- `stall_i` in IDLE or DONE has no effect.
- Reset mid-FILL: the next cycle is the reset state. No `done_o` is issued and the command is discarded.

## Timing
- Accept at cycle N. First write (`we_o`=1, (xmin,ymin)) at cycle N+1 if not stalled.
- Last write at cycle L. `done_o`=1 at L+1. `cmd_ready_o`=1 at L+2. The earliest next accept is L+2.
- Each stall cycle adds exactly one cycle of latency. Addresses hold their values during a stall.
- Unstalled command latency (accept to `done_o`) = write count + 1 cycles.

## Configuration
- `RECT_FILL_CLIP_EN` defined:
  - After normalisation, xmax is clamped to HD-1 and ymax to VD-1.
  - If xmin>=HD or ymin>=VD, the FSM goes IDLE→DONE directly with zero writes; `done_o` still pulses once.
- `RECT_FILL_CLIP_EN` undefined:
  - No clamping; any in-width coordinate is emitted unchanged.
  - Neither HD nor VD is referenced.

## Structure
- Shared package `vga_pkg`:
  - `HD`, `VD`, `X_BITS`, `Y_BITS`, `COLOR_BITS` constants.
  - `rect_state_e` enum (IDLE, FILL, DONE).
  - `rect_cmd_t` struct (x0, y0, x1, y1, color).
- One sub-module, `rect_cmd_norm`: combinational min/max swap and the optional clip, plus an `empty` flag. Its output is registered on accept by the top-level FSM.

## Test plan
- Command (10,20)-(12,21), colour 2: exactly 6 writes, in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all with `color_o`=2. `done_o` follows one cycle after (12,21).
- Swapped corners (12,21)-(10,20): the same 6 writes, in the same order.
- Single pixel (0,0)-(0,0): one write at N+1, `done_o` at N+2, `cmd_ready_o` at N+3. A second `cmd_valid_i` held during busy is accepted only at N+3.
- Command (0,0)-(3,0) with `stall_i` high for 3 cycles after the second write: `we_o`=0 and the address is held at (2,0) during the stall; then (2,0), (3,0). Total 4 writes, `done_o` 1 cycle after the last write.
- `rst_i` asserted during the third write of (0,0)-(7,7): the next cycle shows `we_o`=0, `busy_o`=0, `cmd_ready_o`=1, and `done_o` never pulses.
- Clip, (1270,1020)-(1300,1030):
  - With `RECT_FILL_CLIP_EN`: 40 writes, last at (1279,1023).
  - Without `RECT_FILL_CLIP_EN`: 341 writes.
  - With `RECT_FILL_CLIP_EN`, command (1300,0)-(1310,5): zero writes and a single `done_o` pulse.
